// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Two-port round-robin arbiter and sequencer for the 4 KiB word-addressed
// data memory. Requester m0 (CPU load/store) and m1 (DMA/debug loader) share
// the single memory port. Each access is latched at grant, driven to the
// memory for exactly one ACCESS cycle and completed with a one-cycle ack
// (RESP cycle) carrying the read data.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   m0_req/we/addr/wdata     requester 0 request inputs
//   m0_gnt/ack/rdata         requester 0 grant (ACCESS), done pulse, read data
//   m1_*                     same set for requester 1
//   dm_we/addr/din           data memory write enable, word address, write data
//   dm_dout                  data memory combinational read data
// Parameter
//   RR_INIT                  requester holding priority after reset (0 or 1)
// ---------------------------------------------------------------------------
module dm_arbiter #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [9:0]  m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [9:0]  m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        dm_we,
   output logic [9:0]  dm_addr,
   output logic [31:0] dm_din,
   input  logic [31:0] dm_dout
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]  state_r;
   logic        prio_r;
   logic        owner_r;
   logic        req_we_r;
   logic [9:0]  req_addr_r;
   logic [31:0] req_wdata_r;
   logic        m0_gnt_r;
   logic        m1_gnt_r;
   logic        m0_ack_r;
   logic        m1_ack_r;
   logic        dm_we_r;
   logic [31:0] m0_rdata_r;
   logic [31:0] m1_rdata_r;

   logic        any_req_s;
   logic        winner_s;
   logic        sel_we_s;
   logic [9:0]  sel_addr_s;
   logic [31:0] sel_wdata_s;

   // Arbitration: a lone requester wins outright, a tie goes to prio_r.
   always_comb begin
      any_req_s   = m0_req | m1_req;
      winner_s    = 1'b0;
      if (m0_req && m1_req) begin
         winner_s = prio_r;
      end else if (m1_req) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
      if (winner_s) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

   // Sequencer FSM with registered gnt/ack/dm_we decodes; priority rotates on
   // every grant, including grants made without contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         prio_r   <= RR_INIT;
         owner_r  <= 1'b0;
         m0_gnt_r <= 1'b0;
         m1_gnt_r <= 1'b0;
         m0_ack_r <= 1'b0;
         m1_ack_r <= 1'b0;
         dm_we_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  state_r  <= ST_ACCESS;
                  owner_r  <= winner_s;
                  prio_r   <= ~winner_s;
                  m0_gnt_r <= ~winner_s;
                  m1_gnt_r <= winner_s;
                  dm_we_r  <= sel_we_s;
               end
            end
            ST_ACCESS: begin
               state_r  <= ST_RESP;
               m0_gnt_r <= 1'b0;
               m1_gnt_r <= 1'b0;
               dm_we_r  <= 1'b0;
               m0_ack_r <= ~owner_r;
               m1_ack_r <= owner_r;
            end
            ST_RESP: begin
               state_r  <= ST_IDLE;
               m0_ack_r <= 1'b0;
               m1_ack_r <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               m0_gnt_r <= 1'b0;
               m1_gnt_r <= 1'b0;
               m0_ack_r <= 1'b0;
               m1_ack_r <= 1'b0;
               dm_we_r  <= 1'b0;
            end
         endcase
      end
   end

   // Request register: captured only at grant so later input changes cannot
   // disturb the access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_we_r    <= 1'b0;
         req_addr_r  <= 10'd0;
         req_wdata_r <= 32'd0;
      end else if ((state_r == ST_IDLE) && any_req_s) begin
         req_we_r    <= sel_we_s;
         req_addr_r  <= sel_addr_s;
         req_wdata_r <= sel_wdata_s;
      end
   end

   // Read data capture on the ACCESS closing edge; writes leave rdata alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m0_rdata_r <= 32'd0;
         m1_rdata_r <= 32'd0;
      end else if ((state_r == ST_ACCESS) && !req_we_r) begin
         if (owner_r) begin
            m1_rdata_r <= dm_dout;
         end else begin
            m0_rdata_r <= dm_dout;
         end
      end
   end

   assign m0_gnt   = m0_gnt_r;
   assign m1_gnt   = m1_gnt_r;
   assign m0_ack   = m0_ack_r;
   assign m1_ack   = m1_ack_r;
   assign m0_rdata = m0_rdata_r;
   assign m1_rdata = m1_rdata_r;
   assign dm_we    = dm_we_r;
   assign dm_addr  = req_addr_r;
   assign dm_din   = req_wdata_r;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port round-robin arbiter and sequencer for the 4 KiB word-addressed data memory. It lets two requesters share the single memory port: the CPU load/store unit on m0 and a DMA/debug loader on m1. Each access is latched at grant, driven to the memory for exactly one cycle, and completed with a one-cycle ack carrying read data. The block sits between the requesters and the data memory's we/addr/din/dout pins.

## Interface
- RR_INIT, 0: requester that holds priority after reset (0 or 1).
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  requester 0 access request.
- m0_we  in  1  requester 0 write (1) / read (0).
- m0_addr  in  10  requester 0 word address [11:2].
- m0_wdata  in  32  requester 0 write data.
- m0_gnt  out  1  requester 0 access in progress (ACCESS cycle).
- m0_ack  out  1  requester 0 access complete, one-cycle pulse.
- m0_rdata  out  32  requester 0 read data, valid while m0_ack=1 after a read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata: same as m0_*, for requester 1.
- dm_we  out  1  memory write enable.
- dm_addr  out  10  memory word address.
- dm_din  out  32  memory write data.
- dm_dout  in  32  memory combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: pick the winner, latch its we/addr/wdata into the request register, record the owner, go to ACCESS.
- Arbitration:
  - One req high: that requester wins.
  - Both high: the requester holding priority (prio register) wins.
  - After every grant, prio moves to the other requester, even if only one requester was active.
- ACCESS (exactly one cycle):
  - owner's gnt=1; dm_we = latched we; dm_addr/dm_din = latched values.
  - On the closing edge a write commits in memory.
  - On a read, dm_dout is captured into the owner's rdata register.
  - Next state: RESP.
- RESP (exactly one cycle): owner's ack=1, then go to IDLE.
- rdata retention: each m*_rdata holds its last read value until that requester's next read completes. Writes leave rdata unchanged.
- Requester rules:
  - Hold req, we, addr and wdata stable until sampled in IDLE.
  - The request is latched at grant. Later changes, including dropping req, do not affect the in-flight access.
  - req seen during ACCESS or RESP is ignored.
  - req still high in the following IDLE cycle is a new access, using the values present at that time.
- dm_addr/dm_din always reflect the request register. dm_we is 0 outside ACCESS.
- Reset values:
  - state=IDLE; prio=RR_INIT.
  - request register = 0, so dm_addr=0, dm_din=0, dm_we=0.
  - gnt=0 and ack=0 on both ports; m0_rdata=m1_rdata=0.

## Timing
- Request sampled on edge k, in IDLE.
- gnt=1 and dm_we (for writes) during cycle k..k+1.
- Write committed and read data captured on edge k+1.
- ack=1 during cycle k+1..k+2; IDLE from edge k+2.
- Latency from sampling edge to ack: 1 cycle to grant, 2 cycles to ack.
- Peak throughput: one access per 3 cycles.
- Contention with both requests continuously high: grants alternate strictly (m_p, m_!p, m_p, ...). A waiting requester is served no later than the next arbitration.
- Read-after-write from either requester to the same address returns the new data, because accesses are serialized.
- Async reset asserted mid-ACCESS: dm_we, gnt and ack drop immediately. A pending write whose commit edge has not occurred is discarded. The FSM is in IDLE on rst release.
- Reset during RESP: ack drops immediately and rdata clears to 0.
- gnt and ack are registered-state decodes, glitch-free, and mutually exclusive across ports.

## Test plan
- Single read, m0 only:
  - Stimulus: preload dm[5]=32'hDEADBEEF; m0_req=1, m0_we=0, m0_addr=5 sampled on edge 1.
  - Required: m0_gnt=1 in cycle 1-2; m0_ack=1 and m0_rdata=32'hDEADBEEF in cycle 2-3; m1 outputs stay 0.
- Write then read, m1:
  - Stimulus: m1 writes 32'h12345678 to addr 10'h3FF (wrap-edge address), then reads addr 10'h3FF.
  - Required: dm_we=1 for exactly one cycle; the read acks with 32'h12345678; m1_rdata is unchanged after the write ack.
- Contention:
  - Stimulus: after reset with RR_INIT=0, hold m0_req=m1_req=1 for 12 cycles, each requester using a distinct address.
  - Required: grant order m0, m1, m0, m1; 4 acks total, one every 3 cycles.
- Priority rotation with a single active requester:
  - Stimulus: m1 alone completes one access; then both requests rise in the same cycle.
  - Required: m0 wins.
- Request dropped after grant:
  - Stimulus: m0 write to addr 7 with data 32'hA5A5A5A5; m0_req and m0_wdata change during ACCESS.
  - Required: dm[7]=32'hA5A5A5A5 and ack is still issued.
- Reset mid-ACCESS:
  - Stimulus: assert rst asynchronously during an m0 write ACCESS, before its commit edge.
  - Required: dm_we, gnt and ack go to 0 immediately; the target word is unchanged; after release the FSM is IDLE with prio=RR_INIT and both rdata=0.
